// File: rtl/load_memory.sv
// load_memory: single-port word memory for the load stations; one read per transaction, memReady after LATENCY cycles.
// Build option MEM_WRITE_EN adds the storeMem write port; without it the array is a zero-initialised ROM.
module load_memory #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        loadMem,
   input  logic [15:0] memAddr,
   output logic        memReady,
   output logic [15:0] memOut,
   output logic        busy
`ifdef MEM_WRITE_EN
   ,
   input  logic        storeMem,
   input  logic [15:0] storeAddr,
   input  logic [15:0] storeData
`endif
);

   // state | meaning
   // IDLE  | waiting for loadMem; word is sampled on acceptance
   // BUSY  | counting down the remaining latency
   // DONE  | memReady pulse, held word on memOut
   localparam int DEPTH = 2**ADDR_BITS;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   state_t               state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [15:0]          data_q, data_d;
   logic [15:0]          out_q, out_d;
   logic [15:0]          mem_q [DEPTH];
   logic [ADDR_BITS-1:0] rd_idx;

   assign rd_idx = memAddr[ADDR_BITS-1:0];

   // Upper address bits only select the wrap-around alias and are dropped.
   generate
      if (ADDR_BITS < 16) begin : g_unused_hi
         logic unused_addr_hi;
`ifdef MEM_WRITE_EN
         assign unused_addr_hi = ^{memAddr[15:ADDR_BITS], storeAddr[15:ADDR_BITS]};
`else
         assign unused_addr_hi = ^memAddr[15:ADDR_BITS];
`endif
      end
   endgenerate

   initial begin
`ifdef MEM_WRITE_EN
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`else
      for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
`endif
   end

`ifdef MEM_WRITE_EN
   // Writes are never blocked by the read FSM; the read side samples the old word.
   always_ff @(posedge clk) begin
      if (storeMem) mem_q[storeAddr[ADDR_BITS-1:0]] <= storeData;
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      out_d    = out_q;
      memReady = 1'b0;
      busy     = 1'b0;
      memOut   = out_q;
      case (state_q)
         ST_IDLE: begin
            if (loadMem) begin
               data_d  = mem_q[rd_idx];
               cnt_d   = 8'(LATENCY - 1);
               state_d = (LATENCY == 1) ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            busy  = 1'b1;
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = ST_DONE;
         end
         ST_DONE: begin
            busy     = 1'b1;
            memReady = 1'b1;
            memOut   = data_q;
            out_d    = data_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         out_q   <= out_d;
      end
   end

endmodule

// File: tb/tb_load_memory.sv
// Self-checking bench for load_memory: directed scenarios plus a randomized run against a timing/array model.
module tb_load_memory;
   localparam int L  = 3;
   localparam int AB = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        loadMem = 1'b0;
   logic [15:0] memAddr = '0;
   logic        memReady;
   logic [15:0] memOut;
   logic        busy;
`ifdef MEM_WRITE_EN
   logic        storeMem = 1'b0;
   logic [15:0] storeAddr = '0;
   logic [15:0] storeData = '0;
`endif

   int checks = 0;
   int failures = 0;

   // reference model: array image plus acceptance time of the outstanding request
   logic [15:0] mem_m [2**AB];
   int          cyc = 0;
   bit          m_pend = 1'b0;
   int          m_acc = 0;
   logic [15:0] m_data = '0;
   logic [15:0] m_out = '0;
   bit          e_ready = 1'b0;
   bit          e_busy = 1'b0;

   always #5 clk = ~clk;

   load_memory #(.ADDR_BITS(AB), .LATENCY(L)) dut (
      .clk(clk), .reset(reset), .loadMem(loadMem), .memAddr(memAddr),
      .memReady(memReady), .memOut(memOut), .busy(busy)
`ifdef MEM_WRITE_EN
      , .storeMem(storeMem), .storeAddr(storeAddr), .storeData(storeData)
`endif
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // One clock edge: advance the model with the inputs the DUT samples, then settle.
   task automatic tick();
      logic [AB-1:0] ra;
      @(posedge clk);
      cyc++;
      if (reset) begin
         m_pend = 1'b0;
         m_out  = '0;
      end else begin
         if (loadMem && (!m_pend || cyc > m_acc + L)) begin
            ra     = memAddr[AB-1:0];
            m_pend = 1'b1;
            m_acc  = cyc;
            m_data = mem_m[ra];
         end else if (m_pend && cyc > m_acc + L) begin
            m_pend = 1'b0;
         end
         if (m_pend && cyc == m_acc + L - 1) m_out = m_data;
      end
`ifdef MEM_WRITE_EN
      if (storeMem) mem_m[storeAddr[AB-1:0]] = storeData;
`endif
      e_ready = m_pend && (cyc == m_acc + L - 1);
      e_busy  = m_pend && (cyc <= m_acc + L - 1);
      #1;
   endtask

   task automatic poke(input logic [AB-1:0] a, input logic [15:0] v);
`ifdef MEM_WRITE_EN
      storeMem  = 1'b1;
      storeAddr = {{(16-AB){1'b0}}, a};
      storeData = v;
      tick();
      storeMem  = 1'b0;
`else
      dut.mem_q[a] = v;
      mem_m[a]     = v;
`endif
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      loadMem = 1'b1;
      memAddr = 16'h0012;
      tick();
      tick();
      checks++;
      if (memReady !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", memReady); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (memOut !== 16'h0000) begin failures++; $display("FAIL reset_out: got %h want 0000", memOut); end
      reset   = 1'b0;
      loadMem = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_load_ignored: busy got %b want 0", busy); end
   endtask

   task automatic test_basic_read();
      int pulses = 0;
      poke(8'h12, 16'hBEEF);
      loadMem = 1'b1;
      memAddr = 16'h0012;
      tick();
      loadMem = 1'b0;
      for (int i = 1; i <= L + 3; i++) begin
         if (i > 1) tick();
         checks++;
         if (memReady !== (i == L)) begin
            failures++; $display("FAIL basic_ready_t%0d: got %b want %b", i, memReady, (i == L));
         end
         if (memReady === 1'b1) pulses++;
         if (i >= L) begin
            checks++;
            if (memOut !== 16'hBEEF) begin failures++; $display("FAIL basic_out_t%0d: got %h want beef", i, memOut); end
         end
      end
      checks++;
      if (pulses != 1) begin failures++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_wrap();
      logic [15:0] v;
      int lat = -1;
      v = 16'($urandom) | 16'h0001;
      poke(8'h05, v);
      loadMem = 1'b1;
      memAddr = 16'h0105;
      tick();
      loadMem = 1'b0;
      for (int i = 1; i <= L + 4 && lat < 0; i++) begin
         if (i > 1) tick();
         if (memReady === 1'b1) lat = i;
      end
      checks++;
      if (lat != L) begin failures++; $display("FAIL wrap_latency: got %0d want %0d", lat, L); end
      checks++;
      if (memOut !== v) begin failures++; $display("FAIL wrap_out: got %h want %h", memOut, v); end
      tick();
   endtask

   task automatic test_ignored_while_busy();
      int pulses = 0;
      poke(8'h01, 16'hA1A1);
      poke(8'h02, 16'hB2B2);
      loadMem = 1'b1;
      memAddr = 16'h0001;
      tick();
      if (memReady === 1'b1) pulses++;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL busy_second_strobe: busy got %b want 1", busy); end
      memAddr = 16'h0002;
      tick();
      if (memReady === 1'b1) pulses++;
      loadMem = 1'b0;
      for (int i = 0; i < L + 3; i++) begin
         tick();
         if (memReady === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin failures++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
      checks++;
      if (memOut !== 16'hA1A1) begin failures++; $display("FAIL busy_out: got %h want a1a1", memOut); end
   endtask

`ifdef MEM_WRITE_EN
   task automatic test_store_same_cycle();
      bit seen = 1'b0;
      poke(8'h07, 16'h0000);
      storeMem  = 1'b1;
      storeAddr = 16'h0007;
      storeData = 16'h1234;
      loadMem   = 1'b1;
      memAddr   = 16'h0007;
      tick();
      storeMem = 1'b0;
      loadMem  = 1'b0;
      for (int i = 0; i < L + 4 && !seen; i++) begin
         if (memReady === 1'b1) seen = 1'b1; else tick();
      end
      checks++;
      if (!seen || memOut !== 16'h0000) begin
         failures++; $display("FAIL rbw_old: got %h ready_seen=%0d want 0000", memOut, seen);
      end
      tick();
      loadMem = 1'b1;
      tick();
      loadMem = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < L + 4 && !seen; i++) begin
         if (memReady === 1'b1) seen = 1'b1; else tick();
      end
      checks++;
      if (!seen || memOut !== 16'h1234) begin
         failures++; $display("FAIL rbw_new: got %h ready_seen=%0d want 1234", memOut, seen);
      end
      tick();
   endtask
`endif

   task automatic test_reset_in_busy();
      int pulses = 0;
      bit seen = 1'b0;
      poke(8'h30, 16'h7777);
      poke(8'h20, 16'h5A5A);
      loadMem = 1'b1;
      memAddr = 16'h0030;
      tick();
      loadMem = 1'b0;
      if (memReady === 1'b1) pulses++;
      tick();
      if (memReady === 1'b1) pulses++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < L + 3; i++) begin
         if (memReady === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL rstbusy_pulses: got %0d want 0", pulses); end
      checks++;
      if (memOut !== 16'h0000) begin failures++; $display("FAIL rstbusy_out: got %h want 0000", memOut); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL rstbusy_busy: got %b want 0", busy); end
      loadMem = 1'b1;
      memAddr = 16'h0020;
      tick();
      loadMem = 1'b0;
      for (int i = 1; i <= L + 4 && !seen; i++) begin
         if (i > 1) tick();
         if (memReady === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || memOut !== 16'h5A5A) begin
         failures++; $display("FAIL rstbusy_after: got %h ready_seen=%0d want 5a5a", memOut, seen);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 64; i++) poke(8'($urandom), 16'($urandom));
      for (int n = 0; n < 600; n++) begin
         reset   = ($urandom_range(0, 59) == 0);
         loadMem = ($urandom_range(0, 1) == 1);
         memAddr = 16'($urandom);
`ifdef MEM_WRITE_EN
         storeMem  = ($urandom_range(0, 2) == 0);
         storeAddr = ($urandom_range(0, 3) == 0) ? memAddr : 16'($urandom);
         storeData = 16'($urandom);
`endif
         tick();
         checks++;
         if (memReady !== e_ready) begin failures++; $display("FAIL rand_ready_c%0d: got %b want %b", cyc, memReady, e_ready); end
         checks++;
         if (busy !== e_busy) begin failures++; $display("FAIL rand_busy_c%0d: got %b want %b", cyc, busy, e_busy); end
         checks++;
         if (memOut !== m_out) begin failures++; $display("FAIL rand_out_c%0d: got %h want %h", cyc, memOut, m_out); end
      end
      reset   = 1'b0;
      loadMem = 1'b0;
`ifdef MEM_WRITE_EN
      storeMem = 1'b0;
`endif
      tick();
   endtask

   initial begin
      for (int i = 0; i < 2**AB; i++) mem_m[i] = '0;
      test_reset();
      test_basic_read();
      test_wrap();
      test_ignored_while_busy();
`ifdef MEM_WRITE_EN
      test_store_same_cycle();
`endif
      test_reset_in_busy();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
